// File: rtl/memory_cycle_pkg.sv
// Shared core constants for the memory stage.
// Datapath width, register index width, default data-memory depth.
package memory_cycle_pkg;

  localparam int XLEN              = 32;
  localparam int REG_ADDR_W        = 5;
  localparam int DEFAULT_MEM_DEPTH = 1024;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-addressed data memory: async read, sync 32-bit write.
// Ports: clk, rst (active-low), WE, A (byte addr), WD, RD.
module data_memory
  import memory_cycle_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WE,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] WD,
  output logic [XLEN-1:0] RD
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [XLEN-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]   idx;
  logic            unused_addr;

  // Byte offset and bits above the array wrap are dropped.
  assign idx         = A[AW+1:2];
  assign unused_addr = ^{A[XLEN-1:AW+2], A[1:0]};

  assign RD = mem[idx];

  // Array is never cleared; reset only blocks stores.
  always_ff @(posedge clk) begin
    if (rst && WE) begin
      mem[idx] <= WD;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: data memory plus the M/W pipeline register.
// Ports: clk, rst (async active-low), *M inputs, *W registered outputs.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic                  ResultSrcM,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [XLEN-1:0]       WriteDataM,
  input  logic [XLEN-1:0]       ALU_ResultM,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [REG_ADDR_W-1:0] RD_W,
  output logic [XLEN-1:0]       PCPlus4W,
  output logic [XLEN-1:0]       ALU_ResultW,
  output logic [XLEN-1:0]       ReadDataW
);

  logic [XLEN-1:0] read_data;

  data_memory #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_dmem (
    .clk(clk),
    .rst(rst),
    .WE (MemWriteM),
    .A  (ALU_ResultM),
    .WD (WriteDataM),
    .RD (read_data)
  );

  // read_data is sampled before the same-edge store lands,
  // giving read-before-write on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= read_data;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle.
// Each task drives one scenario and checks W outputs inline.
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;

  int asserts;
  int fails;

  memory_cycle #(.MEM_DEPTH(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RD_M       (RD_M),
    .PCPlus4M   (PCPlus4M),
    .WriteDataM (WriteDataM),
    .ALU_ResultM(ALU_ResultM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RD_W       (RD_W),
    .PCPlus4W   (PCPlus4W),
    .ALU_ResultW(ALU_ResultW),
    .ReadDataW  (ReadDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic mw,
                       input logic rs, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] wd,
                       input logic [31:0] a);
    RegWriteM   = rw;
    MemWriteM   = mw;
    ResultSrcM  = rs;
    RD_M        = rd;
    PCPlus4M    = pc;
    WriteDataM  = wd;
    ALU_ResultM = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h44, 32'h0, 32'h8);
    step();
    step();
    asserts++;
    if ({RegWriteW, ResultSrcW, RD_W} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0",
               {RegWriteW, ResultSrcW, RD_W});
    end
    asserts++;
    if ({PCPlus4W, ALU_ResultW, ReadDataW} !== 96'd0) begin
      fails++;
      $display("FAIL reset_data got %h %h %h want 0",
               PCPlus4W, ALU_ResultW, ReadDataW);
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_store_load();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h4, 32'hDEADBEEF, 32'h10);
    step();
    asserts++;
    if (RegWriteW !== 1'b0) begin
      fails++;
      $display("FAIL store_bubble RegWriteW got %b want 0", RegWriteW);
    end
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h8, 32'h0, 32'h10);
    step();
    asserts++;
    if (ReadDataW !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL load_data got %h want deadbeef", ReadDataW);
    end
    asserts++;
    if ({RegWriteW, ResultSrcW, RD_W} !== {1'b1, 1'b1, 5'd5}) begin
      fails++;
      $display("FAIL load_ctrl got %b %b %0d want 1 1 5",
               RegWriteW, ResultSrcW, RD_W);
    end
  endtask

  task automatic test_read_before_write();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h11111111, 32'h20);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h22222222, 32'h20);
    step();
    asserts++;
    if (ReadDataW !== 32'h11111111) begin
      fails++;
      $display("FAIL rbw_old got %h want 11111111", ReadDataW);
    end
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0, 32'h20);
    step();
    asserts++;
    if (ReadDataW !== 32'h22222222) begin
      fails++;
      $display("FAIL rbw_new got %h want 22222222", ReadDataW);
    end
  endtask

  task automatic test_wrap_align();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hA5A5A5A5, 32'h1004);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h0, 32'h0, 32'h4);
    step();
    asserts++;
    if (ReadDataW !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL wrap got %h want a5a5a5a5", ReadDataW);
    end
    drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h0, 32'h0, 32'h7);
    step();
    asserts++;
    if (ReadDataW !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL align got %h want a5a5a5a5", ReadDataW);
    end
    asserts++;
    if (ALU_ResultW !== 32'h7) begin
      fails++;
      $display("FAIL align_alu got %h want 00000007", ALU_ResultW);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h100, 32'h12345678, 32'h40);
    step();
    asserts++;
    if (RD_W !== 5'd9 || PCPlus4W !== 32'h100) begin
      fails++;
      $display("FAIL pre_reset got %0d %h want 9 00000100",
               RD_W, PCPlus4W);
    end
    #2 rst = 1'b0;
    #1;
    asserts++;
    if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
         ReadDataW} !== 103'd0) begin
      fails++;
      $display("FAIL async_clear got %b %b %0d %h %h %h want 0",
               RegWriteW, ResultSrcW, RD_W, PCPlus4W,
               ALU_ResultW, ReadDataW);
    end
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h0, 32'hFFFF0000, 32'h40);
    step();
    asserts++;
    if (ReadDataW !== 32'h0 || RD_W !== 5'd0) begin
      fails++;
      $display("FAIL held_reset got %h %0d want 0 0", ReadDataW, RD_W);
    end
    #2 rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h40);
    step();
    asserts++;
    if (ReadDataW !== 32'h12345678) begin
      fails++;
      $display("FAIL retain got %h want 12345678", ReadDataW);
    end
    asserts++;
    if (RD_W !== 5'd4) begin
      fails++;
      $display("FAIL resume RD_W got %0d want 4", RD_W);
    end
  endtask

  task automatic test_passthrough();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0BADF00D, 32'hFFC);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd31, 32'h104, 32'h77777777,
          32'hFFFFFFFF);
    step();
    asserts++;
    if ({RegWriteW, ResultSrcW, RD_W} !== {1'b1, 1'b0, 5'd31}) begin
      fails++;
      $display("FAIL pass_ctrl got %b %b %0d want 1 0 31",
               RegWriteW, ResultSrcW, RD_W);
    end
    asserts++;
    if (PCPlus4W !== 32'h104 || ALU_ResultW !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL pass_data got %h %h want 00000104 ffffffff",
               PCPlus4W, ALU_ResultW);
    end
    asserts++;
    if (ReadDataW !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL pass_read got %h want 0badf00d", ReadDataW);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'hFFC);
    step();
    asserts++;
    if (ReadDataW !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL pass_nowrite got %h want 0badf00d", ReadDataW);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h10);
    step();
    asserts++;
    if (ReadDataW !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL other_word got %h want deadbeef", ReadDataW);
    end
  endtask

  initial begin
    asserts = 0;
    fails   = 0;
    rst     = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_store_load();
    test_read_before_write();
    test_wrap_align();
    test_async_reset();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, data-memory depth in 32-bit words; must be a power of two, at least 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RegWriteM  input  1  register-file write enable from execute stage.
REQ-005 SHALL have port MemWriteM  input  1  data-memory store enable.
REQ-006 SHALL have port ResultSrcM  input  1  writeback select: 0 = ALU result, 1 = load data.
REQ-007 SHALL have port RD_M  input  5  destination register index.
REQ-008 SHALL have port PCPlus4M  input  32  PC+4 of the instruction.
REQ-009 SHALL have port WriteDataM  input  32  store data (already forwarded).
REQ-010 SHALL have port ALU_ResultM  input  32  byte address for load/store, or ALU result.
REQ-011 SHALL have port RegWriteW  output  1  registered RegWriteM.
REQ-012 SHALL have port ResultSrcW  output  1  registered ResultSrcM.
REQ-013 SHALL have port RD_W  output  5  registered RD_M.
REQ-014 SHALL have port PCPlus4W  output  32  registered PCPlus4M.
REQ-015 SHALL have port ALU_ResultW  output  32  registered ALU_ResultM.
REQ-016 SHALL have port ReadDataW  output  32  registered load data.

Function
REQ-017 SHALL index memory by word address ALU_ResultM[AW+1:2], where AW = log2(MEM_DEPTH).
- ALU_ResultM[1:0] ignored: no misalignment trap.
- Upper bits ignored: addresses wrap modulo MEM_DEPTH*4 bytes.
REQ-018 SHALL perform a store on the rising edge when MemWriteM=1 and rst=1.
- Writes the full 32-bit WriteDataM to the indexed word.
- No byte or halfword enables.
REQ-019 SHALL read combinationally from the indexed word every cycle, whatever MemWriteM is.
REQ-020 SHALL return the pre-store word on ReadData when a read and a store hit the same word in the same cycle (read-before-write).
REQ-021 SHALL make a store at edge N visible to a load presented in the cycle after edge N.
REQ-022 SHALL register all six W outputs on each rising edge while rst=1.
- Latency: exactly 1 cycle, M inputs to W outputs.
- No stall or flush input: the register loads every cycle.
REQ-023 SHALL keep RegWriteW, ResultSrcW and RD_W independent of MemWriteM; a store with RegWriteM=0 propagates as a bubble.
REQ-024 SHALL not produce X on ReadDataW for an unwritten word after a write to it.
- Unwritten words are undefined until first written.
- The bench must write before reading.

Reset
REQ-025 SHALL immediately force RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW and ReadDataW to 0 while rst=0, independent of clk.
REQ-026 SHALL block all memory stores while rst=0, including an edge coincident with reset assertion.
REQ-027 SHALL retain data-memory contents across reset; the array is not cleared.
REQ-028 SHALL resume normal capture on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL put the data array in one sub-module, data_memory.
- Ports: clk, rst, WE, A[31:0], WD[31:0], RD[31:0].
- Asynchronous read, synchronous write.
REQ-030 SHALL place the shared constants in the shared core package: XLEN=32, REG_ADDR_W=5, default MEM_DEPTH=1024. No typedefs are needed.
REQ-031 SHALL contain only the memory array and the M/W pipeline register; writeback muxing belongs to the writeback stage.

Verification
REQ-032 Store then load: store 0xDEADBEEF to 0x00000010, then next cycle load 0x00000010 with ResultSrcM=1, RegWriteM=1, RD_M=5 -> one cycle later ReadDataW=0xDEADBEEF, RD_W=5, RegWriteW=1, ResultSrcW=1.
REQ-033 Read-before-write: word 0x20 holds 0x11111111; present store 0x22222222 and a read of 0x20 in the same cycle -> ReadDataW=0x11111111; next-cycle read -> 0x22222222.
REQ-034 Wrap and alignment: with MEM_DEPTH=1024, store 0xA5A5A5A5 to 0x00001004 -> load of 0x00000004 returns 0xA5A5A5A5; load of 0x00000007 returns 0xA5A5A5A5.
REQ-035 Async reset mid-operation: drop rst between edges while W outputs are nonzero -> all W outputs 0 before the next edge; a store presented during reset leaves the word unchanged; the word written before reset still reads back after rst=1.
REQ-036 Passthrough: RegWriteM=1, ResultSrcM=0, RD_M=31, PCPlus4M=0x00000104, ALU_ResultM=0xFFFFFFFF, MemWriteM=0 -> next cycle W outputs match exactly; no memory word changes.
